// File: rtl/ram_1r1w_sync.sv
// Synchronous 1-read / 1-write RAM with registered, read-first output.
// Out-of-range writes are dropped and out-of-range reads return zero.
module ram_1r1w_sync #(
    parameter int unsigned width_p = 32,
    parameter int unsigned depth_p = 1024,
    localparam int unsigned aw = $clog2(depth_p)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               wr_valid_i,
    input  logic [width_p-1:0] wr_data_i,
    input  logic [aw-1:0]      wr_addr_i,
    input  logic               rd_valid_i,
    input  logic [aw-1:0]      rd_addr_i,
    output logic [width_p-1:0] rd_data_o
);

    // One extra bit so depth_p itself is representable for the range compare.
    localparam logic [aw:0] depth_l = (aw+1)'(depth_p);

    logic [width_p-1:0] mem [0:depth_p-1];
    logic [width_p-1:0] rd_data_q;
    logic               wr_in_range;
    logic               rd_in_range;

    always_comb begin
        wr_in_range = ({1'b0, wr_addr_i} < depth_l);
        rd_in_range = ({1'b0, rd_addr_i} < depth_l);
    end

    // Storage is never reset so preloaded contents survive reset.
    always_ff @(posedge clk_i) begin
        if (reset_i && wr_valid_i && wr_in_range) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Non-blocking read of mem gives read-first on a same-address collision.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            rd_data_q <= '0;
        end else if (rd_valid_i) begin
            rd_data_q <= rd_in_range ? mem[rd_addr_i] : '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_ram_1r1w_sync.sv
// Directed bench for ram_1r1w_sync; a non-power-of-two depth exercises the
// out-of-range address handling.
module tb_ram_1r1w_sync;

    localparam int unsigned W = 32;
    localparam int unsigned D = 12;
    localparam int unsigned A = $clog2(D);

    logic         clk;
    logic         reset;
    logic         wr_valid;
    logic [W-1:0] wr_data;
    logic [A-1:0] wr_addr;
    logic         rd_valid;
    logic [A-1:0] rd_addr;
    logic [W-1:0] rd_data;

    int n_checks = 0;
    int n_pass   = 0;

    ram_1r1w_sync #(
        .width_p(W),
        .depth_p(D)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .wr_valid_i(wr_valid),
        .wr_data_i (wr_data),
        .wr_addr_i (wr_addr),
        .rd_valid_i(rd_valid),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic rst, input logic wv, input logic [A-1:0] wa,
                         input logic [W-1:0] wd, input logic rv, input logic [A-1:0] ra);
        reset    = rst;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        rd_valid = rv;
        rd_addr  = ra;
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] expected);
        n_checks++;
        assert (rd_data === expected) n_pass++;
        else $error("FAIL %s: rd_data=%h expected=%h", tag, rd_data, expected);
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0);

        // Reset clears the output register.
        step();
        step();
        check("reset_clears", 32'h0);

        // Write then read back.
        drive(1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, '0);
        step();
        drive(1'b1, 1'b0, '0, '0, 1'b1, 4'd5);
        step();
        check("wr_rd_addr5", 32'hDEADBEEF);

        // Read-first on same-address collision.
        drive(1'b1, 1'b1, 4'd3, 32'h11111111, 1'b0, '0);
        step();
        drive(1'b1, 1'b1, 4'd3, 32'h22222222, 1'b1, 4'd3);
        step();
        check("collide_old", 32'h11111111);
        drive(1'b1, 1'b0, '0, '0, 1'b1, 4'd3);
        step();
        check("collide_new", 32'h22222222);

        // Output holds while rd_valid is low.
        drive(1'b1, 1'b1, 4'd8, 32'h12345678, 1'b0, '0);
        step();
        drive(1'b1, 1'b0, '0, '0, 1'b1, 4'd8);
        step();
        check("hold_load", 32'h12345678);
        drive(1'b1, 1'b1, 4'd1, 32'h0000_0001, 1'b0, 4'd1);
        step();
        check("hold_1", 32'h12345678);
        drive(1'b1, 1'b1, 4'd2, 32'h0000_0002, 1'b0, 4'd2);
        step();
        check("hold_2", 32'h12345678);
        drive(1'b1, 1'b1, 4'd4, 32'h0000_0004, 1'b0, 4'd4);
        step();
        check("hold_3", 32'h12345678);

        // Simultaneous read and write at different addresses.
        drive(1'b1, 1'b1, 4'd6, 32'hCAFE0006, 1'b1, 4'd2);
        step();
        check("diff_addr_rd", 32'h0000_0002);
        drive(1'b1, 1'b0, '0, '0, 1'b1, 4'd6);
        step();
        check("diff_addr_wr", 32'hCAFE0006);

        // Memory persists across reset; reads suppressed during reset.
        drive(1'b1, 1'b1, 4'd7, 32'hA5A5A5A5, 1'b0, '0);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd7);
        step();
        check("rst_mid_1", 32'h0);
        step();
        check("rst_mid_2", 32'h0);
        drive(1'b1, 1'b0, '0, '0, 1'b1, 4'd7);
        step();
        check("rst_persist", 32'hA5A5A5A5);

        // Write during reset is suppressed.
        drive(1'b1, 1'b1, 4'd9, 32'h0BADF00D, 1'b0, '0);
        step();
        drive(1'b0, 1'b1, 4'd9, 32'hFFFFFFFF, 1'b1, 4'd9);
        step();
        check("rst_wr_out", 32'h0);
        drive(1'b1, 1'b0, '0, '0, 1'b1, 4'd9);
        step();
        check("rst_wr_blocked", 32'h0BADF00D);

        // First and last address, no aliasing.
        drive(1'b1, 1'b1, 4'd0, 32'h0000_0AAA, 1'b0, '0);
        step();
        drive(1'b1, 1'b1, 4'(D-1), 32'h0000_BBBB, 1'b0, '0);
        step();
        drive(1'b1, 1'b0, '0, '0, 1'b1, 4'd0);
        step();
        check("addr_first", 32'h0000_0AAA);
        drive(1'b1, 1'b0, '0, '0, 1'b1, 4'(D-1));
        step();
        check("addr_last", 32'h0000_BBBB);

        // Out-of-range write must not disturb in-range words; out-of-range read is zero.
        drive(1'b1, 1'b1, 4'd12, 32'h5555_5555, 1'b0, '0);
        step();
        drive(1'b1, 1'b1, 4'd15, 32'h7777_7777, 1'b0, '0);
        step();
        drive(1'b1, 1'b0, '0, '0, 1'b1, 4'd4);
        step();
        check("oor_wr_no_alias4", 32'h0000_0004);
        drive(1'b1, 1'b0, '0, '0, 1'b1, 4'd15);
        step();
        check("oor_rd15_zero", 32'h0);
        drive(1'b1, 1'b0, '0, '0, 1'b1, 4'd7);
        step();
        check("oor_reload7", 32'hA5A5A5A5);
        drive(1'b1, 1'b0, '0, '0, 1'b1, 4'd12);
        step();
        check("oor_rd12_zero", 32'h0);
        drive(1'b1, 1'b0, '0, '0, 1'b1, 4'd0);
        step();
        check("oor_no_alias0", 32'h0000_0AAA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_1r1w_sync.md
RAM_1R1W_SYNC -- requirements
Module: ram_1r1w_sync

Interface
REQ-001 SHALL have parameter width_p, default 32: data word width in bits.
REQ-002 SHALL have parameter depth_p, default 1024: number of words (>=2).
REQ-003 SHALL derive address width aw = $clog2(depth_p); this is a localparam, not overridable.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 SHALL have port clk_i, input, 1: clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_i, input, 1: synchronous active-low reset.
REQ-007 SHALL have port wr_valid_i, input, 1: write enable.
REQ-008 SHALL have port wr_data_i, input, width_p: write data.
REQ-009 SHALL have port wr_addr_i, input, aw: write word address.
REQ-010 SHALL have port rd_valid_i, input, 1: read enable.
REQ-011 SHALL have port rd_addr_i, input, aw: read word address.
REQ-012 SHALL have port rd_data_o, output, width_p: registered read data.
REQ-013 SHALL hold storage in an unpacked array named mem, indexed [0:depth_p-1], each entry width_p bits, so a parent can load it by hierarchical $readmemh.

Function
REQ-014 SHALL be a single write port and a single read port, fully independent, usable in the same cycle.
REQ-015 SHALL, at a rising edge with wr_valid_i=1 and reset_i=1, store wr_data_i into mem[wr_addr_i].
REQ-016 SHALL, at a rising edge with rd_valid_i=1 and reset_i=1, load rd_data_o with mem[rd_addr_i]; read latency is exactly one cycle.
REQ-017 SHALL hold rd_data_o unchanged at edges where rd_valid_i=0.
REQ-018 SHALL have read-first behaviour on same-address read and write in one cycle: rd_data_o gets the old word, and the new word is visible from the next read.
REQ-019 SHALL, for different-address simultaneous read and write, complete both with no interaction.
REQ-020 SHALL ignore writes with wr_addr_i >= depth_p, leaving memory unchanged.
REQ-021 SHALL return all zeros in rd_data_o for reads with rd_addr_i >= depth_p.
REQ-022 SHALL use no combinational path from any input to rd_data_o.
REQ-023 SHALL have no busy/stall output; one operation per port per cycle, no backpressure.

Reset
REQ-024 SHALL, at a rising edge with reset_i=0, clear rd_data_o to 0 and suppress any read or write in that cycle.
REQ-025 SHALL NOT clear or alter mem contents on reset; contents persist across reset, preserving preloaded data.
REQ-026 SHALL leave mem contents undefined (X in simulation) at power-up unless preloaded.
REQ-027 SHALL apply reset dominance: a reset asserted mid-sequence aborts that cycle's operations only; operations after deassertion behave normally.

Verification
REQ-028 SHALL pass this case: write 0xDEADBEEF to addr 5, then read addr 5 the next cycle -> rd_data_o=0xDEADBEEF one cycle after the read edge.
REQ-029 SHALL pass this case: mem[3]=0x11111111; in one cycle write 0x22222222 to addr 3 and read addr 3 -> rd_data_o=0x11111111; reading addr 3 next cycle -> 0x22222222.
REQ-030 SHALL pass this case: after a read yields 0x12345678, drop rd_valid_i for 3 cycles while writing other addresses -> rd_data_o stays 0x12345678.
REQ-031 SHALL pass this case: write 0xA5A5A5A5 to addr 7, assert reset_i=0 for 2 cycles -> rd_data_o=0; after release, read addr 7 -> 0xA5A5A5A5.
REQ-032 SHALL pass this case: in a reset cycle with wr_valid_i=1 writing 0xFFFFFFFF to addr 9 -> a later read of addr 9 still returns its pre-reset value.
REQ-033 SHALL pass this case: writes to addr 0 and addr depth_p-1 with distinct values -> both read back correctly, with no aliasing.
